// File: rtl/zmips_muldiv.sv
// zmips_muldiv: iterative 33-cycle HI/LO multiply/divide unit.
// Define ZMIPS_MULDIV_DIV_EN to build in the restoring divider.
module zmips_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] op_m;
  logic        neg_q;

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] prod;

  assign sgn   = ~op[0];
  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;

  // acc_lo holds the multiplier and shifts out one bit per step
  assign mul_sum = {1'b0, acc_hi}
                 + (acc_lo[0] ? {1'b0, op_m} : 33'd0);

  assign prod = neg_q ? (64'd0 - {acc_hi, acc_lo})
                      : {acc_hi, acc_lo};

`ifdef ZMIPS_MULDIV_DIV_EN
  logic        is_div;
  logic        neg_r;
  logic        b_zero;
  logic [31:0] a_raw;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_sub;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign rem_sh  = {acc_hi, acc_lo[31]};
  assign fits    = rem_sh >= {1'b0, op_m};
  assign rem_sub = rem_sh[31:0] - op_m;
  assign q_fix   = neg_q ? (32'd0 - acc_lo) : acc_lo;
  assign r_fix   = neg_r ? (32'd0 - acc_hi) : acc_hi;
`else
  logic        pend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      op_m   <= 32'd0;
      neg_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
`ifdef ZMIPS_MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= 32'd0;
`else
      pend   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifndef ZMIPS_MULDIV_DIV_EN
      pend <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (hi_wr) hi <= wr_data;
          if (lo_wr) lo <= wr_data;
`ifdef ZMIPS_MULDIV_DIV_EN
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            cnt    <= 5'd0;
            acc_hi <= 32'd0;
            acc_lo <= op[1] ? a_mag : b_mag;
            op_m   <= op[1] ? b_mag : a_mag;
            neg_q  <= a_neg ^ b_neg;
            is_div <= op[1];
            neg_r  <= a_neg;
            b_zero <= (b == 32'd0);
            a_raw  <= a;
          end
`else
          // divide requests are acknowledged without touching hi/lo
          if (pend) done <= 1'b1;
          if (start && op[1]) begin
            pend <= 1'b1;
          end else if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            cnt    <= 5'd0;
            acc_hi <= 32'd0;
            acc_lo <= b_mag;
            op_m   <= a_mag;
            neg_q  <= a_neg ^ b_neg;
          end
`endif
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
`ifdef ZMIPS_MULDIV_DIV_EN
          if (is_div) begin
            acc_hi <= fits ? rem_sub : rem_sh[31:0];
            acc_lo <= {acc_lo[30:0], fits};
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
`else
          acc_hi <= mul_sum[32:1];
          acc_lo <= {mul_sum[0], acc_lo[31:1]};
`endif
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef ZMIPS_MULDIV_DIV_EN
          if (is_div && b_zero) begin
            hi <= a_raw;
            lo <= 32'hFFFF_FFFF;
          end else if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
`else
          hi <= prod[63:32];
          lo <= prod[31:0];
`endif
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zmips_muldiv.sv
// tb_zmips_muldiv: directed vectors for zmips_muldiv.
// Divider vectors run only when ZMIPS_MULDIV_DIV_EN is defined.
module tb_zmips_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  zmips_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k counts edges after E0; bc counts busy samples seen
  task automatic wait_done(input int k0,
                           output int k,
                           output int bc);
    k  = k0;
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) bc++;
      tick();
      k++;
      if (done) return;
    end
  endtask

  task automatic launch(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_chk(input string tag,
                         input logic [1:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [31:0] eh,
                         input logic [31:0] el);
    int k;
    int bc;
    launch(o, x, y);
    wait_done(0, k, bc);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_lat"}, k, 33);
  endtask

  initial begin
    int k;
    int bc;
    int seen;
    rst     = 1'b1;
    start   = 1'b0;
    op      = MULT;
    a       = 32'd0;
    b       = 32'd0;
    hi_wr   = 1'b0;
    lo_wr   = 1'b0;
    wr_data = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    lo_wr   = 1'b1;
    wr_data = 32'hCAFE_BABE;
    tick();
    lo_wr = 1'b0;
    chk("mtlo", lo, 32'hCAFE_BABE);
    hi_wr   = 1'b1;
    wr_data = 32'h1357_2468;
    tick();
    hi_wr = 1'b0;
    chk("mthi", hi, 32'h1357_2468);

`ifdef ZMIPS_MULDIV_DIV_EN
    run_chk("div_neg", DIV, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_chk("divu_z", DIVU, 32'd100, 32'd0,
            32'h0000_0064, 32'hFFFF_FFFF);
    run_chk("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000);
    run_chk("div_nb", DIV, 32'd7, 32'hFFFF_FFFE,
            32'd1, 32'hFFFF_FFFD);
    run_chk("div_z", DIV, 32'hFFFF_FFFB, 32'd0,
            32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_chk("divu", DIVU, 32'hFFFF_FFFF, 32'd10,
            32'd5, 32'h1999_9999);
`else
    launch(DIV, 32'd7, 32'd2);
    chk("nodiv_busy0", busy, 0);
    chk("nodiv_done0", done, 0);
    tick();
    chk("nodiv_done1", done, 1);
    chk("nodiv_busy1", busy, 0);
    chk("nodiv_lo", lo, 32'hCAFE_BABE);
    chk("nodiv_hi", hi, 32'h1357_2468);
    tick();
    chk("nodiv_done2", done, 0);
`endif

    launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, k, bc);
    chk("mu_hi", hi, 32'hFFFF_FFFE);
    chk("mu_lo", lo, 32'h0000_0001);
    chk("mu_lat", k, 33);
    chk("mu_busy_cyc", bc, 33);
    chk("mu_busy_done", busy, 0);
    tick();
    chk("mu_done_pulse", done, 0);

    run_chk("m_neg", MULT, 32'hFFFF_FFFD, 32'd7,
            32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_chk("m_pn", MULT, 32'h0001_0000, 32'hFFFF_0000,
            32'hFFFF_FFFF, 32'h0);
    run_chk("m_min", MULT, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 32'h0);
    run_chk("mu_min", MULTU, 32'h8000_0000, 32'h3,
            32'h1, 32'h8000_0000);

    // ignored start/mthi while busy, operand changes after E0
    launch(MULTU, 32'd3, 32'd5);
    a = 32'd999;
    b = 32'd999;
    for (int i = 0; i < 4; i++) tick();
    op    = MULT;
    a     = 32'd7;
    start = 1'b1;
    tick();
    start   = 1'b0;
    hi_wr   = 1'b1;
    wr_data = 32'h1234;
    tick();
    hi_wr = 1'b0;
    wait_done(6, k, bc);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd15);
    chk("ign_lat", k, 33);

    // start accepted in the done cycle, with same-edge mthi
    hi_wr   = 1'b1;
    wr_data = 32'hABCD_0001;
    launch(MULTU, 32'd2, 32'd3);
    hi_wr = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_mthi", hi, 32'hABCD_0001);
    wait_done(0, k, bc);
    chk("b2b_hi", hi, 32'h0);
    chk("b2b_lo", lo, 32'd6);
    chk("b2b_lat", k, 33);

    launch(MULTU, 32'd9, 32'd9);
    chk("b2b2_busy", busy, 1);
    wait_done(0, k, bc);
    chk("b2b2_lo", lo, 32'd81);

    // abort by reset at E0+10
    launch(MULTU, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    chk("abort_nodone", seen, 0);
    chk("abort_lo_end", lo, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/zmips_muldiv.md
ZMIPS_MULDIV -- requirements
Module: zmips_muldiv

Interface
REQ-001 Port clk; input; 1 bit; single clock; all state updates on rising edge.
REQ-002 Port rst; input; 1 bit; synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 Port start; input; 1 bit; request a new operation; sampled only in IDLE.
REQ-004 Port op; input; 2 bits; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 Port a; input; 32 bits; operand rs (multiplicand / dividend), driven from regfile read port 0.
REQ-006 Port b; input; 32 bits; operand rt (multiplier / divisor), driven from regfile read port 1.
REQ-007 Port hi_wr / lo_wr; input; 1 bit each; MTHI / MTLO write strobes.
REQ-008 Port wr_data; input; 32 bits; data for hi_wr / lo_wr.
REQ-009 Port busy; output; 1 bit; high while an operation is in RUN or FIX.
REQ-010 Port done; output; 1 bit; one-cycle pulse when hi/lo hold a new result.
REQ-011 Port hi / lo; output; 32 bits each; architectural HI/LO registers, registered outputs.

Function
REQ-012 FSM states: IDLE, RUN, FIX; 5-bit iteration counter cnt.
REQ-013 IDLE & start at edge E0: latch op, |a|, |b| (magnitudes for signed ops, raw for unsigned), result signs; cnt=0; go RUN.
REQ-014 RUN: one radix-2 step per edge; shift-add multiply, restoring divide; cnt increments; after 32nd step (cnt wraps 31->0) go FIX.
REQ-015 FIX: apply sign correction, write hi/lo, go IDLE; done=1 in cycle following FIX edge (edge E0+33).
REQ-016 Latency fixed: 33 edges start-to-result for every op, including divide by zero.
REQ-017 busy=1 from edge E0 through FIX edge; busy=0 in the done cycle.
REQ-018 start while busy: ignored, no queueing; start in the done cycle (IDLE): accepted.
REQ-019 MULT/MULTU: {hi,lo} = full 64-bit product; MULT two's-complement signed.
REQ-020 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero; remainder takes dividend sign.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000 (wraps, no trap).
REQ-022 Divide by zero (any sign): lo=0xFFFFFFFF, hi=a as latched at E0.
REQ-023 hi_wr / lo_wr honoured only when busy=0; ignored while busy; same-edge start + hi_wr: write takes effect, later overwritten by result.
REQ-024 Operands a/b need only be valid at E0; later changes do not affect result.

Reset
REQ-025 rst=1 at any edge: state IDLE, cnt=0, hi=0, lo=0, busy=0, done=0; overrides start, hi_wr, lo_wr.
REQ-026 rst mid-operation aborts it: no done pulse, no hi/lo update from the aborted op.

Configuration
REQ-027 Macro ZMIPS_MULDIV_DIV_EN defined: divider datapath compiled in, DIV/DIVU per REQ-020..022.
REQ-028 Macro not defined: no divider logic; start with op[1]=1 does not enter RUN, hi/lo unchanged, busy stays 0, done pulses at E0+1; MULT/MULTU unaffected.

Verification
REQ-029 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly at E0+33, busy high 33 cycles.
REQ-030 MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 DIV a=0xFFFFFFF9 (-7) b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-032 MULTU 3*5 started, start with new op pulsed at E0+5 and hi_wr=1 wr_data=0x1234 at E0+6 -> both ignored, result hi=0, lo=15.
REQ-033 MULTU started, rst at E0+10 -> busy=0, hi=lo=0 next cycle, no done pulse over following 40 cycles.
REQ-034 Idle lo_wr wr_data=0xCAFEBABE -> lo=0xCAFEBABE next cycle; build without ZMIPS_MULDIV_DIV_EN: DIV start -> done at E0+1, busy=0, lo unchanged.
